// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive chain.
// Holds the packet-level FSM states and the fixed BLE framing sizes.
package ble_rx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAccessAddr,
      StHeader,
      StPayload,
      StCrc
   } rx_state_e;

   localparam int unsigned AA_LEN    = 32;
   localparam int unsigned HDR_BYTES = 2;
   localparam int unsigned CRC_BYTES = 3;

   localparam logic [31:0] ADV_ACCESS_ADDR = 32'h8E89BED6;

   // Header length byte limited to the largest payload we are willing to buffer.
   function automatic logic [5:0] clamp_len(input logic [7:0] len, input int unsigned max_len);
      if ({24'd0, len} > max_len) begin
         return max_len[5:0];
      end
      return len[5:0];
   endfunction

endpackage

// File: rtl/symbol_sampler.sv
// Symbol phase counter: loads to mid-symbol on a preamble hit and emits one
// sample strobe per symbol while the receiver is active.
module symbol_sampler #(
   parameter int unsigned SAMPLE_RATE = 16
) (
   input  logic clk,
   input  logic resetn,
   input  logic en,
   input  logic load,
   input  logic active,
   output logic strobe
);

   localparam int unsigned PW = $clog2(SAMPLE_RATE);
   localparam logic [PW-1:0] PHASE_HALF = PW'(SAMPLE_RATE / 2);
   localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLE_RATE - 1);

   logic [PW-1:0] phase_q, phase_d;

   always_comb begin
      phase_d = phase_q;
      if (en) begin
         if (load) begin
            phase_d = PHASE_HALF;
         end else if (!active) begin
            phase_d = '0;
         end else if (phase_q == PHASE_LAST) begin
            phase_d = '0;
         end else begin
            phase_d = phase_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign strobe = en && active && (phase_q == PHASE_LAST);

endmodule

// File: rtl/access_address_sync.sv
// BLE access-address search and PDU byte deserialiser, fed by the preamble
// detector; emits header, payload and CRC bytes LSB-first.
module access_address_sync
   import ble_rx_pkg::*;
#(
   parameter int unsigned SAMPLE_RATE   = 16,
   parameter int unsigned MAX_PDU_LEN   = 37,
   parameter int unsigned AA_MAX_ERRORS = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic        data_bit,
   input  logic        preamble_detected,
   input  logic [31:0] access_address,
   output logic        aa_matched,
   output logic        aa_failed,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        packet_done,
   output logic        busy
);

   localparam logic [5:0] AA_LAST   = 6'(AA_LEN - 1);
   localparam logic [5:0] HDR_LAST  = 6'(HDR_BYTES - 1);
   localparam logic [5:0] CRC_LAST  = 6'(CRC_BYTES - 1);
   localparam logic [5:0] BYTE_LAST = 6'd7;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < 32; i++) begin
         cnt = cnt + {5'd0, v[i]};
      end
      return cnt;
   endfunction

   rx_state_e   state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]  byte_cnt_q, byte_cnt_d;
   logic [5:0]  pdu_len_q, pdu_len_d;
   // Only the previously received bits are stored; the newest bit comes from data_bit.
   logic [30:0] aa_shift_q, aa_shift_d;
   logic [6:0]  byte_shift_q, byte_shift_d;
   logic [7:0]  byte_out_q, byte_out_d;
   logic        aa_matched_q, aa_matched_d;
   logic        aa_failed_q, aa_failed_d;
   logic        byte_valid_q, byte_valid_d;
   logic        packet_done_q, packet_done_d;

   logic        strobe;
   logic        start;
   logic        active;
   logic [31:0] aa_next;
   logic [7:0]  byte_next;
   logic [5:0]  aa_errors;
   logic        aa_ok;
   logic [5:0]  len_clamped;

   assign active      = (state_q != StIdle);
   assign start       = en && !active && preamble_detected;
   assign aa_next     = {data_bit, aa_shift_q};
   assign byte_next   = {data_bit, byte_shift_q};
   assign aa_errors   = popcount32(aa_next ^ access_address);
   assign aa_ok       = ({26'd0, aa_errors} <= AA_MAX_ERRORS);
   assign len_clamped = clamp_len(byte_next, MAX_PDU_LEN);

   symbol_sampler #(
      .SAMPLE_RATE (SAMPLE_RATE)
   ) u_sampler (
      .clk    (clk),
      .resetn (resetn),
      .en     (en),
      .load   (start),
      .active (active),
      .strobe (strobe)
   );

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      pdu_len_d     = pdu_len_q;
      aa_shift_d    = aa_shift_q;
      byte_shift_d  = byte_shift_q;
      byte_out_d    = byte_out_q;
      aa_matched_d  = 1'b0;
      aa_failed_d   = 1'b0;
      byte_valid_d  = 1'b0;
      packet_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StAccessAddr;
               bit_cnt_d = '0;
            end
         end

         StAccessAddr: begin
            if (strobe) begin
               aa_shift_d = aa_next[31:1];
               bit_cnt_d  = bit_cnt_q + 6'd1;
               if (bit_cnt_q == AA_LAST) begin
                  bit_cnt_d  = '0;
                  byte_cnt_d = '0;
                  if (aa_ok) begin
                     state_d      = StHeader;
                     aa_matched_d = 1'b1;
                  end else begin
                     state_d     = StIdle;
                     aa_failed_d = 1'b1;
                  end
               end
            end
         end

         StHeader, StPayload, StCrc: begin
            if (strobe) begin
               byte_shift_d = byte_next[7:1];
               bit_cnt_d    = bit_cnt_q + 6'd1;
               if (bit_cnt_q == BYTE_LAST) begin
                  bit_cnt_d    = '0;
                  byte_out_d   = byte_next;
                  byte_valid_d = 1'b1;
                  byte_cnt_d   = byte_cnt_q + 6'd1;
                  if (state_q == StHeader) begin
                     if (byte_cnt_q == HDR_LAST) begin
                        pdu_len_d  = len_clamped;
                        byte_cnt_d = '0;
                        state_d    = (len_clamped == 6'd0) ? StCrc : StPayload;
                     end
                  end else if (state_q == StPayload) begin
                     if (byte_cnt_q + 6'd1 == pdu_len_q) begin
                        byte_cnt_d = '0;
                        state_d    = StCrc;
                     end
                  end else begin
                     if (byte_cnt_q == CRC_LAST) begin
                        byte_cnt_d    = '0;
                        packet_done_d = 1'b1;
                        state_d       = StIdle;
                     end
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         pdu_len_q     <= '0;
         aa_shift_q    <= '0;
         byte_shift_q  <= '0;
         byte_out_q    <= '0;
         aa_matched_q  <= 1'b0;
         aa_failed_q   <= 1'b0;
         byte_valid_q  <= 1'b0;
         packet_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         pdu_len_q     <= pdu_len_d;
         aa_shift_q    <= aa_shift_d;
         byte_shift_q  <= byte_shift_d;
         byte_out_q    <= byte_out_d;
         aa_matched_q  <= aa_matched_d;
         aa_failed_q   <= aa_failed_d;
         byte_valid_q  <= byte_valid_d;
         packet_done_q <= packet_done_d;
      end
   end

   assign aa_matched  = aa_matched_q;
   assign aa_failed   = aa_failed_q;
   assign byte_out    = byte_out_q;
   assign byte_valid  = byte_valid_q;
   assign packet_done = packet_done_q;
   assign busy        = active;

endmodule
